// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MIPS opcode constants, the hazard FSM state
// type and small opcode-class helpers used by the ID-stage hazard logic.
package pipeline_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {
        RUN     = 1'b0,
        BR_HOLD = 1'b1
    } state_e;

    // Instructions that read rt as a source operand (for lw, rt is a destination).
    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic op_is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Source-operand comparator: does an in-flight destination register feed
// the instruction in ID? Register 0 is hardwired and never matches.
module hazard_match
    import pipeline_pkg::*;
(
    input  logic [4:0] dest_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       uses_rt_i,
    output logic       match_o
);

    // A nonzero destination matching rs, or rt when rt is actually read.
    always_comb begin
        match_o = (dest_i != 5'd0) &&
                  ((dest_i == rs_i) || (uses_rt_i && (dest_i == rt_i)));
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector: stalls PC/IFID and bubbles IDEX for load-use
// hazards and for ID-resolved branches whose operands are still in flight;
// flushes IFID on a taken branch/jump that is not stalled.
// Optional build macro: STALL_COUNTER_EN adds the saturating Stall_Count output.
//
// state   | meaning
// RUN     | normal decode; hazards evaluated combinationally
// BR_HOLD | second stall cycle of a branch that depends on a load in EX
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [31:0] Instruction_IN,
    input  logic [4:0]  IDEX_RegT,
    input  logic [4:0]  IDEX_RegD,
    input  logic        IDEX_MemRead,
    input  logic        IDEX_RegWrite,
    input  logic [4:0]  EXMEM_RegD,
    input  logic        EXMEM_MemRead,
    input  logic        Branch_Taken,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IDEX_Bubble,
    output logic        IFID_Flush,
    output logic        Stalled_Q
`ifdef STALL_COUNTER_EN
    ,
    output logic [COUNT_WIDTH-1:0] Stall_Count
`endif
);

    if (COUNT_WIDTH < 1) begin : g_bad_width
        $error("COUNT_WIDTH must be at least 1");
    end

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_branch;
    logic       unused_imm;

    assign op         = Instruction_IN[31:26];
    assign rs         = Instruction_IN[25:21];
    assign rt         = Instruction_IN[20:16];
    assign unused_imm = ^Instruction_IN[15:0];
    assign uses_rt    = op_uses_rt(op);
    assign is_branch  = op_is_branch(op);

    logic match_idex_t;
    logic match_idex_d;
    logic match_exmem_d;

    hazard_match u_match_idex_t (
        .dest_i    (IDEX_RegT),
        .rs_i      (rs),
        .rt_i      (rt),
        .uses_rt_i (uses_rt),
        .match_o   (match_idex_t)
    );

    hazard_match u_match_idex_d (
        .dest_i    (IDEX_RegD),
        .rs_i      (rs),
        .rt_i      (rt),
        .uses_rt_i (uses_rt),
        .match_o   (match_idex_d)
    );

    hazard_match u_match_exmem_d (
        .dest_i    (EXMEM_RegD),
        .rs_i      (rs),
        .rt_i      (rt),
        .uses_rt_i (uses_rt),
        .match_o   (match_exmem_d)
    );

    logic load_use;
    logic br_alu;
    logic br_load_near;
    logic br_load_far;

    assign load_use     = IDEX_MemRead && match_idex_t;
    assign br_alu       = is_branch && IDEX_RegWrite && !IDEX_MemRead && match_idex_d;
    assign br_load_near = is_branch && IDEX_MemRead && match_idex_t;
    assign br_load_far  = is_branch && EXMEM_MemRead && match_exmem_d;

    state_e state_q, state_d;
    logic   stall;

    // State register; reset abandons any pending branch hold.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stall decision.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            RUN: begin
                stall = load_use || br_alu || br_load_near || br_load_far;
                if (br_load_near) begin
                    state_d = BR_HOLD;
                end
            end
            BR_HOLD: begin
                stall   = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Pipeline controls; reset freezes the pipeline regardless of the FSM.
    always_comb begin
        PC_Write    = RESET_N && !stall;
        IFID_Write  = RESET_N && !stall;
        IDEX_Bubble = !RESET_N || stall;
        IFID_Flush  = RESET_N && Branch_Taken && (state_q == RUN) && !stall;
    end

    // One-cycle-delayed stall indication.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            Stalled_Q <= 1'b0;
        end else begin
            Stalled_Q <= stall;
        end
    end

`ifdef STALL_COUNTER_EN
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // Saturating count of stall cycles; holds at all-ones rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (stall && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Stall_Count = count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit. Build with or without STALL_COUNTER_EN;
// the counter checks are present only when the macro is defined.
module tb_hazard_stall_unit;

    localparam int CW = 4;

    logic        CLOCK;
    logic        RESET_N;
    logic [31:0] Instruction_IN;
    logic [4:0]  IDEX_RegT;
    logic [4:0]  IDEX_RegD;
    logic        IDEX_MemRead;
    logic        IDEX_RegWrite;
    logic [4:0]  EXMEM_RegD;
    logic        EXMEM_MemRead;
    logic        Branch_Taken;
    logic        PC_Write;
    logic        IFID_Write;
    logic        IDEX_Bubble;
    logic        IFID_Flush;
    logic        Stalled_Q;
`ifdef STALL_COUNTER_EN
    logic [CW-1:0] Stall_Count;
`endif

    hazard_stall_unit #(.COUNT_WIDTH(CW)) dut (
        .CLOCK          (CLOCK),
        .RESET_N        (RESET_N),
        .Instruction_IN (Instruction_IN),
        .IDEX_RegT      (IDEX_RegT),
        .IDEX_RegD      (IDEX_RegD),
        .IDEX_MemRead   (IDEX_MemRead),
        .IDEX_RegWrite  (IDEX_RegWrite),
        .EXMEM_RegD     (EXMEM_RegD),
        .EXMEM_MemRead  (EXMEM_MemRead),
        .Branch_Taken   (Branch_Taken),
        .PC_Write       (PC_Write),
        .IFID_Write     (IFID_Write),
        .IDEX_Bubble    (IDEX_Bubble),
        .IFID_Flush     (IFID_Flush),
        .Stalled_Q      (Stalled_Q)
`ifdef STALL_COUNTER_EN
        ,
        .Stall_Count    (Stall_Count)
`endif
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    // Instruction encodings used below.
    localparam logic [31:0] I_NOP      = 32'h0000_0000;
    localparam logic [31:0] I_ADD_423  = {6'h00, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20};
    localparam logic [31:0] I_ADD_400  = {6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20};
    localparam logic [31:0] I_BEQ_56   = {6'h04, 5'd5, 5'd6, 16'h0010};
    localparam logic [31:0] I_BNE_71   = {6'h05, 5'd7, 5'd1, 16'h0020};
    localparam logic [31:0] I_SW_19    = {6'h2B, 5'd1, 5'd9, 16'h0004};
    localparam logic [31:0] I_LW_19    = {6'h23, 5'd1, 5'd9, 16'h0004};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the combinational stall/flush outputs for an expected stall and flush.
    task automatic chk_ctl(input string tag, input logic st, input logic fl);
        chk({tag, ".pc_write"},   {31'd0, PC_Write},    {31'd0, ~st});
        chk({tag, ".ifid_write"}, {31'd0, IFID_Write},  {31'd0, ~st});
        chk({tag, ".bubble"},     {31'd0, IDEX_Bubble}, {31'd0, st});
        chk({tag, ".flush"},      {31'd0, IFID_Flush},  {31'd0, fl});
    endtask

    task automatic chk_cnt(input string tag);
`ifdef STALL_COUNTER_EN
        chk({tag, ".count"}, {{(32-CW){1'b0}}, Stall_Count}, exp_cnt);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // Advance one clock; st is the stall the bench expects at this edge.
    task automatic tick(input logic st);
        @(posedge CLOCK);
        if (st && RESET_N && exp_cnt < (1 << CW) - 1) exp_cnt++;
        #1;
    endtask

    task automatic idle_inputs();
        Instruction_IN = I_NOP;
        IDEX_RegT      = 5'd0;
        IDEX_RegD      = 5'd0;
        IDEX_MemRead   = 1'b0;
        IDEX_RegWrite  = 1'b0;
        EXMEM_RegD     = 5'd0;
        EXMEM_MemRead  = 1'b0;
        Branch_Taken   = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0;
        idle_inputs();
        Instruction_IN = I_ADD_423;
        IDEX_MemRead   = 1'b1;
        IDEX_RegT      = 5'd2;
        Branch_Taken   = 1'b1;
        #2;
        // Reset freezes the pipeline even with a hazard and taken branch present.
        chk_ctl("reset", 1'b1, 1'b0);
        chk("reset.stalled_q", {31'd0, Stalled_Q}, 32'd0);
        chk_cnt("reset");
        #10;
        idle_inputs();
        RESET_N = 1'b1;
        tick(1'b0);

        // Load-use: lw $2 in EX, add $4,$2,$3 in ID -> one stall cycle.
        Instruction_IN = I_ADD_423;
        IDEX_MemRead   = 1'b1;
        IDEX_RegT      = 5'd2;
        #1;
        chk_ctl("load_use", 1'b1, 1'b0);
        chk("load_use.stalled_q_pre", {31'd0, Stalled_Q}, 32'd0);
        tick(1'b1);
        idle_inputs();
        Instruction_IN = I_ADD_423;
        #1;
        chk_ctl("load_use.after", 1'b0, 1'b0);
        chk("load_use.stalled_q", {31'd0, Stalled_Q}, 32'd1);
        chk_cnt("load_use");
        tick(1'b0);
        chk("load_use.stalled_q_clear", {31'd0, Stalled_Q}, 32'd0);

        // Register 0 never hazards.
        Instruction_IN = I_ADD_400;
        IDEX_MemRead   = 1'b1;
        IDEX_RegT      = 5'd0;
        #1;
        chk_ctl("reg0", 1'b0, 1'b0);

        // rt match counts for sw but not for lw (lw's rt is its destination).
        Instruction_IN = I_SW_19;
        IDEX_RegT      = 5'd9;
        #1;
        chk_ctl("sw_rt", 1'b1, 1'b0);
        Instruction_IN = I_LW_19;
        #1;
        chk_ctl("lw_rt", 1'b0, 1'b0);
        tick(1'b0);

        // Branch after load: two stall cycles even if EX changes in cycle 2.
        idle_inputs();
        Instruction_IN = I_BEQ_56;
        IDEX_MemRead   = 1'b1;
        IDEX_RegT      = 5'd5;
        #1;
        chk_ctl("br_load_near.c1", 1'b1, 1'b0);
        tick(1'b1);
        IDEX_MemRead   = 1'b0;
        IDEX_RegT      = 5'd0;
        Branch_Taken   = 1'b1;
        #1;
        chk_ctl("br_load_near.c2", 1'b1, 1'b0);
        chk("br_load_near.stalled_q", {31'd0, Stalled_Q}, 32'd1);
        tick(1'b1);
        chk_ctl("br_load_near.c3", 1'b0, 1'b1);
        chk_cnt("br_load_near");
        tick(1'b0);

        // Branch after ALU op; taken during the stall must not flush.
        idle_inputs();
        Instruction_IN = I_BNE_71;
        IDEX_RegWrite  = 1'b1;
        IDEX_RegD      = 5'd7;
        Branch_Taken   = 1'b1;
        #1;
        chk_ctl("br_alu.stall", 1'b1, 1'b0);
        tick(1'b1);
        IDEX_RegWrite  = 1'b0;
        IDEX_RegD      = 5'd0;
        #1;
        chk_ctl("br_alu.flush", 1'b0, 1'b1);
        chk("br_alu.stalled_q", {31'd0, Stalled_Q}, 32'd1);

        // Branch with a non-writing ID/EX producer: no stall.
        IDEX_RegD      = 5'd7;
        Branch_Taken   = 1'b0;
        #1;
        chk_ctl("br_nowrite", 1'b0, 1'b0);
        tick(1'b0);

        // Branch rt operand fed by a load in MEM: one stall cycle.
        idle_inputs();
        Instruction_IN = I_BEQ_56;
        EXMEM_MemRead  = 1'b1;
        EXMEM_RegD     = 5'd6;
        #1;
        chk_ctl("br_load_far", 1'b1, 1'b0);
        tick(1'b1);
        EXMEM_MemRead  = 1'b0;
        #1;
        chk_ctl("br_load_far.after", 1'b0, 1'b0);
        chk_cnt("br_load_far");
        tick(1'b0);

        // Reset asserted during BR_HOLD.
        idle_inputs();
        Instruction_IN = I_BEQ_56;
        IDEX_MemRead   = 1'b1;
        IDEX_RegT      = 5'd5;
        tick(1'b1);
        idle_inputs();
        Branch_Taken   = 1'b1;
        #1;
        chk_ctl("hold_pre_reset", 1'b1, 1'b0);
        RESET_N = 1'b0;
        exp_cnt = 0;
        #1;
        chk_ctl("reset_mid", 1'b1, 1'b0);
        chk("reset_mid.stalled_q", {31'd0, Stalled_Q}, 32'd0);
        chk_cnt("reset_mid");
        #3;
        Branch_Taken = 1'b0;
        RESET_N = 1'b1;
        #1;
        chk_ctl("reset_release", 1'b0, 1'b0);
        tick(1'b0);
        chk_ctl("reset_after", 1'b0, 1'b0);
        chk("reset_after.stalled_q", {31'd0, Stalled_Q}, 32'd0);

        // Twenty forced stall cycles: counter saturates at 15.
        Instruction_IN = I_ADD_423;
        IDEX_MemRead   = 1'b1;
        IDEX_RegT      = 5'd3;
        for (int i = 0; i < 20; i++) tick(1'b1);
        chk_ctl("saturate", 1'b1, 1'b0);
        chk("saturate.stalled_q", {31'd0, Stalled_Q}, 32'd1);
        chk_cnt("saturate");
        chk("saturate.model", exp_cnt, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- ID-stage hazard detector for the 5-stage MIPS pipeline; the counterpart of the forwarding unit.
- Forwarding resolves operand dependencies in EX; this block finds the dependencies forwarding cannot cover:
  - load-use hazards;
  - ID-resolved branches that depend on in-flight results.
- For those it stalls PC/IFID and injects a bubble into IDEX.
- It also flushes IFID on a taken branch or jump.

Parameters:
- COUNT_WIDTH, 32, width of the stall-cycle performance counter (used only with STALL_COUNTER_EN).

Ports:
- CLOCK  in  1  pipeline clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- Instruction_IN  in  32  instruction currently in IF/ID.
- IDEX_RegT  in  5  rt field of the instruction in ID/EX (load destination).
- IDEX_RegD  in  5  final destination register of the ID/EX instruction.
- IDEX_MemRead  in  1  ID/EX instruction is a load.
- IDEX_RegWrite  in  1  ID/EX instruction writes a register.
- EXMEM_RegD  in  5  destination register of the EX/MEM instruction.
- EXMEM_MemRead  in  1  EX/MEM instruction is a load.
- Branch_Taken  in  1  ID-stage comparator result for beq/bne, or a jump decode.
- PC_Write  out  1  1 = PC may update.
- IFID_Write  out  1  1 = IF/ID register may load.
- IDEX_Bubble  out  1  1 = zero the control bits entering ID/EX.
- IFID_Flush  out  1  1 = IF/ID becomes a nop next edge.
- Stalled_Q  out  1  registered: a stall was asserted in the previous cycle.
- Stall_Count  out  COUNT_WIDTH  stall cycles since reset (only present with STALL_COUNTER_EN).

Behaviour:
- Field decode:
  - rs = Instruction_IN[25:21]; rt = Instruction_IN[20:16]; op = Instruction_IN[31:26].
  - uses_rt is true for op 0x00 (R-type), 0x2B (sw), 0x04 and 0x05 (beq/bne).
  - is_branch is true for op 0x04 and 0x05.
- Register 0 never creates a hazard.
- Match(x) means x != 0 and (x == rs, or uses_rt and x == rt).
- Hazard sources, all evaluated combinationally in RUN:
  - load_use: IDEX_MemRead and Match(IDEX_RegT).
  - br_alu: is_branch and IDEX_RegWrite and not IDEX_MemRead and Match(IDEX_RegD).
  - br_load_near: is_branch and IDEX_MemRead and Match(IDEX_RegT). Needs 2 stall cycles.
  - br_load_far: is_branch and EXMEM_MemRead and Match(EXMEM_RegD).
- FSM has two states, RUN and BR_HOLD. Reset state is RUN.
- RUN:
  - If any hazard: stall = 1.
  - If br_load_near: next state is BR_HOLD; otherwise stay in RUN.
- BR_HOLD:
  - stall = 1 unconditionally; inputs are ignored.
  - Next state is RUN.
- Stall outputs:
  - stall = 1 gives PC_Write = 0, IFID_Write = 0, IDEX_Bubble = 1.
  - stall = 0 gives PC_Write = 1, IFID_Write = 1, IDEX_Bubble = 0.
  - These outputs are combinational; latency is 0 cycles from the hazard to the stall.
- Flush: IFID_Flush = Branch_Taken and (state == RUN) and not stall.
  - When a stall and a taken branch coincide, the stall wins and no flush occurs; the branch re-evaluates after the stall.
- Stalled_Q is stall registered on the CLOCK rising edge.
- While RESET_N = 0:
  - state = RUN, Stalled_Q = 0, Stall_Count = 0.
  - PC_Write = 0, IFID_Write = 0, IDEX_Bubble = 1, IFID_Flush = 0 (pipeline frozen).
- Reset asserted mid-stall (including BR_HOLD) returns to RUN immediately. No pending stall survives reset.
- No X propagation: all outputs are defined for any input value.

Optional Feature:
- Macro STALL_COUNTER_EN.
- When defined: Stall_Count increments by 1 on every rising edge where stall = 1 and RESET_N = 1. It saturates at all-ones (no wrap).
- When undefined: the Stall_Count port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - opcode constants OP_RTYPE = 6'h00, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_LW = 6'h23, OP_SW = 6'h2B;
  - the state enum {RUN, BR_HOLD}.
- One natural sub-module: hazard_match. It is a pure combinational comparator (dest, rs, rt, uses_rt) -> match, including the register-0 exclusion. It is instantiated three times.

Test Plan:
- Load-use: lw $2 in IDEX (IDEX_MemRead = 1, IDEX_RegT = 2), add $4,$2,$3 in IFID -> exactly 1 cycle of PC_Write = 0 / IDEX_Bubble = 1, then Stalled_Q = 1 for one cycle.
- Register 0: lw $0 in IDEX, add $4,$0,$0 in IFID -> no stall, PC_Write = 1.
- Branch after load: lw $5 in IDEX, beq $5,$6 in IFID -> stall for 2 consecutive cycles (RUN then BR_HOLD) even if IDEX inputs change in cycle 2; Stall_Count = 2.
- Branch after ALU op: IDEX_RegWrite = 1, IDEX_RegD = 7, bne $7,$1 -> 1 stall cycle. Branch_Taken = 1 during the stall -> IFID_Flush = 0; on the next RUN cycle with no hazard and Branch_Taken = 1 -> IFID_Flush = 1.
- Reset mid-BR_HOLD: assert RESET_N = 0 asynchronously -> outputs go immediately to the frozen values and Stall_Count = 0. After release -> state RUN, no residual stall.
- Counter saturation (COUNT_WIDTH = 4, STALL_COUNTER_EN defined): 20 forced stall cycles -> Stall_Count holds at 15.
